// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, default PROT and the command FSM encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWr     = 3'd1,
        StWrResp = 3'd2,
        StRdAddr = 3'd3,
        StRdData = 3'd4,
        StResp   = 3'd5
    } axil_state_e;

endpackage

// File: rtl/m_axil_cmd_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface m_axil_cmd_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);

    logic [ADDR_WIDTH+1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH+1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/m_axil_cmd.sv
// AXI4-Lite master: one single-beat read or write per user command, reporting the
// response code and the bus latency measured from command accept to the B/R handshake.
module m_axil_cmd
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LAT_WIDTH  = 16
) (
    input  logic                    axi_clock,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH+1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_we,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [LAT_WIDTH-1:0]    rsp_latency,

    m_axil_cmd_if.master            m_axil
);

    axil_state_e             state;
    logic [ADDR_WIDTH+1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    aw_done;
    logic                    w_done;
    logic [LAT_WIDTH-1:0]    lat_cnt;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    aw_done_nx;
    logic                    w_done_nx;
    logic [LAT_WIDTH-1:0]    lat_inc;

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = PROT_DEFAULT;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = addr_q;
    assign m_axil.arprot  = PROT_DEFAULT;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;

    assign aw_hs      = awvalid_q & m_axil.awready;
    assign w_hs       = wvalid_q & m_axil.wready;
    assign aw_done_nx = aw_done | aw_hs;
    assign w_done_nx  = w_done | w_hs;

    // Saturate rather than wrap so a hung-then-recovered slave never reports a short latency.
    assign lat_inc = (&lat_cnt) ? lat_cnt : lat_cnt + {{(LAT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge axi_clock) begin
        if (rst) begin
            state       <= StIdle;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_we      <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_latency <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            lat_cnt     <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        rsp_we    <= cmd_we;
                        lat_cnt   <= '0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (cmd_we) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= StWr;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= StRdAddr;
                        end
                    end
                end
                StWr: begin
                    lat_cnt <= lat_inc;
                    aw_done <= aw_done_nx;
                    w_done  <= w_done_nx;
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (aw_done_nx && w_done_nx) begin
                        bready_q <= 1'b1;
                        state    <= StWrResp;
                    end
                end
                StWrResp: begin
                    lat_cnt <= lat_inc;
                    if (m_axil.bvalid) begin
                        bready_q    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_resp    <= m_axil.bresp;
                        rsp_latency <= lat_inc;
                        state       <= StResp;
                    end
                end
                StRdAddr: begin
                    lat_cnt <= lat_inc;
                    if (m_axil.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= StRdData;
                    end
                end
                StRdData: begin
                    lat_cnt <= lat_inc;
                    if (m_axil.rvalid) begin
                        rready_q    <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= m_axil.rdata;
                        rsp_resp    <= m_axil.rresp;
                        rsp_latency <= lat_inc;
                        state       <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
